// File: rtl/gc_joybus_host.sv
// gc_joybus_host
// Joybus host for GameCube-style controllers. Periodically sends the 24-bit
// poll command {0x40, 0x03, 7'b0, rumble} on an open-drain line, then
// receives a RESP_BYTES response. Each response bit is decoded by measuring
// its low-pulse width. Complete frames are published atomically with a
// one-cycle valid strobe. No-response and malformed-frame conditions are
// reported as one-cycle error pulses.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset
//   data         Joybus line, only ever pulled low or released (external pull-up)
//   poll_en      enables periodic polling
//   rumble       sampled at poll start, sent as bit 0 of command byte 2
//   resp_data    last good frame, first received bit in the MSB
//   resp_valid   one-cycle pulse when resp_data updates
//   connected    high after a good frame, low after a timeout
//   err_timeout  one-cycle pulse when the pad does not answer
//   err_framing  one-cycle pulse on a malformed response
//   busy         high whenever a transaction is in progress
module gc_joybus_host #(
    parameter int          CLK_HZ     = 100_000_000,
    parameter int          POLL_HZ    = 100,
    parameter int          RESP_BYTES = 8,
    parameter int          TIMEOUT_US = 20,
    parameter logic [63:0] NEUTRAL    = 64'h0000_8080_8080_0000
) (
    input  logic                    clk,
    input  logic                    reset,
    inout  wire                     data,
    input  logic                    poll_en,
    input  logic                    rumble,
    output logic [8*RESP_BYTES-1:0] resp_data,
    output logic                    resp_valid,
    output logic                    connected,
    output logic                    err_timeout,
    output logic                    err_framing,
    output logic                    busy
);

    localparam int CYC    = CLK_HZ / 1_000_000;
    localparam int PERIOD = CLK_HZ / POLL_HZ;
    localparam int DW     = 8 * RESP_BYTES;
    localparam int TMO    = TIMEOUT_US * CYC;
    localparam int CMAX   = (TMO > 4 * CYC) ? TMO : 4 * CYC;
    localparam int CNT_W  = $clog2(CMAX + 1);
    localparam int PW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int LW     = $clog2(8 * CYC + 1);
    localparam int RBW    = $clog2(DW + 1);

    localparam logic [PW-1:0]    POLL_LAST = PW'(PERIOD - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(4 * CYC - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(CYC - 1);
    localparam logic [CNT_W-1:0] STOP_LOW  = CNT_W'(CYC);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TMO - 1);
    localparam logic [CNT_W-1:0] LOW_ONE   = CNT_W'(CYC);
    localparam logic [CNT_W-1:0] LOW_ZERO  = CNT_W'(3 * CYC);
    localparam logic [LW-1:0]    SAT_LAST  = LW'(8 * CYC - 1);
    localparam logic [LW-1:0]    ZERO_MIN  = LW'(2 * CYC);
    localparam logic [RBW-1:0]   RX_BITS   = RBW'(DW);
    localparam logic [DW-1:0]    NEUTRAL_W = NEUTRAL[DW-1:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX,
        S_TX_STOP,
        S_WAIT,
        S_RX,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    poll_cnt_q, poll_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       txbit_q, txbit_d;
    logic             rumble_q, rumble_d;
    logic             drive_q, drive_d;
    logic             sd1_q, sd_q, sd_prev_q;
    logic [LW-1:0]    low_q, low_d;
    logic [LW-1:0]    high_q, high_d;
    logic [RBW-1:0]   rxbit_q, rxbit_d;
    logic [DW-1:0]    shift_q, shift_d;
    logic [DW-1:0]    resp_data_q, resp_data_d;
    logic             connected_q, connected_d;
    logic             err_timeout_q, err_timeout_d;
    logic             err_framing_q, err_framing_d;
    logic             rx_bit;

    // Command bit idx (0 = first transmitted, MSB of the 24-bit word).
    function automatic logic cmd_bit(input logic [4:0] idx, input logic rmb);
        logic [23:0] cmd;
        cmd = {8'h40, 8'h03, 7'b0, rmb};
        return cmd[5'd23 - idx];
    endfunction

    // Low-phase length of one transmitted bit.
    function automatic logic [CNT_W-1:0] low_len(input logic b);
        return b ? LOW_ONE : LOW_ZERO;
    endfunction

    // Open drain: the line is only ever pulled low or released.
    assign data = drive_q ? 1'b0 : 1'bz;

    always_comb begin
        state_d       = state_q;
        poll_cnt_d    = (poll_cnt_q == POLL_LAST) ? '0 : poll_cnt_q + 1'b1;
        cnt_d         = cnt_q;
        txbit_d       = txbit_q;
        rumble_d      = rumble_q;
        low_d         = low_q;
        high_d        = high_q;
        rxbit_d       = rxbit_q;
        shift_d       = shift_q;
        resp_data_d   = resp_data_q;
        connected_d   = connected_q;
        err_timeout_d = 1'b0;
        err_framing_d = 1'b0;
        drive_d       = 1'b0;
        rx_bit        = (low_q < ZERO_MIN);

        case (state_q)
            S_IDLE: begin
                // Ticks arriving while busy are simply lost; only IDLE looks.
                if ((poll_cnt_q == '0) && poll_en) begin
                    state_d  = S_TX;
                    rumble_d = rumble;
                    cnt_d    = '0;
                    txbit_d  = '0;
                end
            end
            S_TX: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (txbit_q == 5'd23) begin
                        state_d = S_TX_STOP;
                    end else begin
                        txbit_d = txbit_q + 5'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_TX_STOP: begin
                if (cnt_q == STOP_LAST) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (sd_prev_q && !sd_q) begin
                    // The sample that showed the edge is the first low cycle.
                    state_d = S_RX;
                    low_d   = LW'(1);
                    high_d  = '0;
                    rxbit_d = '0;
                end else if (cnt_q == TMO_LAST) begin
                    state_d       = S_IDLE;
                    err_timeout_d = 1'b1;
                    connected_d   = 1'b0;
                    resp_data_d   = NEUTRAL_W;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RX: begin
                if (!sd_q) begin
                    if (low_q == SAT_LAST) begin
                        state_d       = S_IDLE;
                        err_framing_d = 1'b1;
                    end else begin
                        low_d = low_q + 1'b1;
                    end
                    high_d = '0;
                end else if (!sd_prev_q) begin
                    // Rising edge: low_q holds the full width of the pulse.
                    if (rxbit_q == RX_BITS) begin
                        if (rx_bit) begin
                            state_d     = S_DONE;
                            resp_data_d = shift_q;
                            connected_d = 1'b1;
                        end else begin
                            state_d       = S_IDLE;
                            err_framing_d = 1'b1;
                        end
                    end else begin
                        shift_d = {shift_q[DW-2:0], rx_bit};
                        rxbit_d = rxbit_q + 1'b1;
                    end
                    low_d  = '0;
                    high_d = LW'(1);
                end else begin
                    if (high_q == SAT_LAST) begin
                        state_d       = S_IDLE;
                        err_framing_d = 1'b1;
                    end else begin
                        high_d = high_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Line drive is registered from next state so the pin never glitches.
        if (state_d == S_TX) begin
            drive_d = (cnt_d < low_len(cmd_bit(txbit_d, rumble_d)));
        end else if (state_d == S_TX_STOP) begin
            drive_d = (cnt_d < STOP_LOW);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            poll_cnt_q    <= '0;
            cnt_q         <= '0;
            txbit_q       <= '0;
            rumble_q      <= 1'b0;
            drive_q       <= 1'b0;
            sd1_q         <= 1'b1;
            sd_q          <= 1'b1;
            sd_prev_q     <= 1'b1;
            low_q         <= '0;
            high_q        <= '0;
            rxbit_q       <= '0;
            resp_data_q   <= NEUTRAL_W;
            connected_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            err_framing_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            poll_cnt_q    <= poll_cnt_d;
            cnt_q         <= cnt_d;
            txbit_q       <= txbit_d;
            rumble_q      <= rumble_d;
            drive_q       <= drive_d;
            sd1_q         <= data;
            sd_q          <= sd1_q;
            sd_prev_q     <= sd_q;
            low_q         <= low_d;
            high_q        <= high_d;
            rxbit_q       <= rxbit_d;
            resp_data_q   <= resp_data_d;
            connected_q   <= connected_d;
            err_timeout_q <= err_timeout_d;
            err_framing_q <= err_framing_d;
        end
    end

    // Receive shifter holds data only; a partial frame is never published.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign resp_data   = resp_data_q;
    assign resp_valid  = (state_q == S_DONE);
    assign connected   = connected_q;
    assign err_timeout = err_timeout_q;
    assign err_framing = err_framing_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_gc_joybus_host.sv
module tb_gc_joybus_host;

    localparam int          CLK_HZ     = 8_000_000;
    localparam int          POLL_HZ    = 1000;
    localparam int          RESP_BYTES = 8;
    localparam int          TIMEOUT_US = 20;
    localparam logic [63:0] NEUTRAL    = 64'h0000_8080_8080_0000;
    localparam int          C          = CLK_HZ / 1_000_000;
    localparam int          T          = TIMEOUT_US * C;
    localparam int          PERIOD     = CLK_HZ / POLL_HZ;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        poll_en = 1'b0;
    logic        rumble = 1'b0;
    logic        dev_low = 1'b0;
    wire         data_w;
    logic [63:0] resp_data;
    logic        resp_valid, connected, err_timeout, err_framing, busy;

    int          n_tests = 0;
    int          n_fail = 0;
    int          n_valid = 0;
    int          n_frm = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_good = NEUTRAL;

    pullup (data_w);
    assign data_w = dev_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    gc_joybus_host #(
        .CLK_HZ    (CLK_HZ),
        .POLL_HZ   (POLL_HZ),
        .RESP_BYTES(RESP_BYTES),
        .TIMEOUT_US(TIMEOUT_US),
        .NEUTRAL   (NEUTRAL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data       (data_w),
        .poll_en    (poll_en),
        .rumble     (rumble),
        .resp_data  (resp_data),
        .resp_valid (resp_valid),
        .connected  (connected),
        .err_timeout(err_timeout),
        .err_framing(err_framing),
        .busy       (busy)
    );

    always @(negedge clk) begin
        if (resp_valid === 1'b1) n_valid++;
        if (err_framing === 1'b1) n_frm++;
    end

    // Decode the host command from the line, starting at (or waiting for) a low.
    task automatic capture_cmd(output logic [23:0] cmd, output int stop_w, output int last_w,
                               output int total, output bit legal, output bit ok);
        int w, h, guard;
        cmd = '0; stop_w = 0; last_w = 0; total = 0; legal = 1'b1; ok = 1'b1;
        guard = 0;
        while (data_w !== 1'b0 && guard < 2 * PERIOD) begin @(negedge clk); guard++; end
        if (data_w !== 1'b0) begin ok = 1'b0; return; end
        for (int p = 0; p < 25; p++) begin
            w = 0;
            while (data_w === 1'b0 && w < 1000) begin @(negedge clk); w++; end
            if (w >= 1000) begin ok = 1'b0; return; end
            total += w;
            if (p < 24) begin
                cmd = {cmd[22:0], (w < 2 * C)};
                if (w != C && w != 3 * C) legal = 1'b0;
                if (p == 23) last_w = w;
                h = 0;
                while (data_w === 1'b1 && h < 1000) begin @(negedge clk); h++; end
                if (h >= 1000) begin ok = 1'b0; return; end
                total += h;
                if (h != 4 * C - w) legal = 1'b0;
            end else begin
                stop_w = w;
            end
        end
    endtask

    // Controller model. hold_at >= 0 holds the line low at that bit and aborts.
    task automatic respond(input logic [63:0] val, input int hold_at, input int hold_len);
        logic        b;
        int          lat;
        logic [63:0] e;
        if (hold_at < 0) exp_q.push_back(val);
        repeat (2 * C) @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            b = val[63 - i];
            if (i == hold_at) begin
                dev_low = 1'b1;
                repeat (hold_len) @(negedge clk);
                dev_low = 1'b0;
                repeat (4 * C) @(negedge clk);
                return;
            end
            dev_low = 1'b1;
            repeat (b ? C : 3 * C) @(negedge clk);
            dev_low = 1'b0;
            repeat (b ? 3 * C : C) @(negedge clk);
        end
        dev_low = 1'b1;
        repeat (C) @(negedge clk);
        dev_low = 1'b0;
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
        n_tests++;
        if (lat != 3) begin
            n_fail++;
            $display("FAIL valid_latency: got %0d cycles after stop release, expected 3", lat);
        end
        if (resp_valid === 1'b1) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
            n_tests++;
            if (resp_data !== e) begin
                n_fail++;
                $display("FAIL resp_data: got %h, expected %h", resp_data, e);
            end
            last_good = e;
            @(negedge clk);
            n_tests++;
            if (resp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL valid_pulse_width: resp_valid=%b one cycle later, expected 0", resp_valid);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; poll_en = 1'b1; rumble = 1'b0; dev_low = 1'b0;
        repeat (5) @(negedge clk);
        n_tests++;
        if ({data_w, connected, resp_valid, err_timeout, err_framing, busy} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_ctrl: line/conn/valid/tmo/frm/busy=%b, expected 100000",
                     {data_w, connected, resp_valid, err_timeout, err_framing, busy});
        end
        n_tests++;
        if (resp_data !== NEUTRAL) begin
            n_fail++;
            $display("FAIL reset_data: got %h, expected %h", resp_data, NEUTRAL);
        end
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({data_w, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL first_poll_start: line/busy=%b, expected 01", {data_w, busy});
        end
    endtask

    task automatic test_first_frame();
        logic [23:0] cmd;
        int          stop_w, last_w, total;
        bit          legal, ok;
        capture_cmd(cmd, stop_w, last_w, total, legal, ok);
        n_tests++;
        if (!ok || cmd !== 24'h400300 || !legal) begin
            n_fail++;
            $display("FAIL cmd_plain: got %h ok=%0d legal=%0d, expected 400300 ok=1 legal=1", cmd, ok, legal);
        end
        n_tests++;
        if (stop_w != C || total != 97 * C) begin
            n_fail++;
            $display("FAIL cmd_timing: stop=%0d total=%0d, expected stop=%0d total=%0d", stop_w, total, C, 97 * C);
        end
        respond(64'h0180_7F81_8080_1020, -1, 0);
        n_tests++;
        if ({connected, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL conn_after_frame: conn/busy=%b, expected 10", {connected, busy});
        end
    endtask

    task automatic test_timeout();
        logic [23:0] cmd;
        int          stop_w, last_w, total, k, v0;
        bit          legal, ok;
        v0 = n_valid;
        capture_cmd(cmd, stop_w, last_w, total, legal, ok);
        k = 0;
        while (err_timeout !== 1'b1 && k < T + 50) begin @(negedge clk); k++; end
        n_tests++;
        if (!ok || k != T) begin
            n_fail++;
            $display("FAIL timeout_delay: got %0d cycles ok=%0d, expected %0d", k, ok, T);
        end
        @(negedge clk);
        n_tests++;
        if ({err_timeout, connected, busy} !== 3'b000 || resp_data !== NEUTRAL) begin
            n_fail++;
            $display("FAIL timeout_state: tmo/conn/busy=%b data=%h, expected 000 %h",
                     {err_timeout, connected, busy}, resp_data, NEUTRAL);
        end
        n_tests++;
        if (n_valid != v0) begin
            n_fail++;
            $display("FAIL timeout_no_valid: got %0d valid pulses, expected 0", n_valid - v0);
        end
    endtask

    task automatic test_rumble();
        logic [23:0] cmd;
        int          stop_w, last_w, total;
        bit          legal, ok;
        rumble = 1'b1;
        fork
            capture_cmd(cmd, stop_w, last_w, total, legal, ok);
            begin
                for (int i = 0; i < 3 * PERIOD && busy !== 1'b1; i++) @(negedge clk);
                poll_en = 1'b0;
                repeat (12) begin repeat (17) @(negedge clk); rumble = ~rumble; end
                rumble = 1'b0;
                poll_en = 1'b1;
            end
        join
        n_tests++;
        if (!ok || cmd !== 24'h400301 || !legal) begin
            n_fail++;
            $display("FAIL cmd_rumble: got %h ok=%0d legal=%0d, expected 400301 ok=1 legal=1", cmd, ok, legal);
        end
        n_tests++;
        if (last_w != C) begin
            n_fail++;
            $display("FAIL rumble_last_low: got %0d, expected %0d", last_w, C);
        end
        respond(64'hFFFF_0000_A5C3_3C5A, -1, 0);
        n_tests++;
        if (connected !== 1'b1) begin
            n_fail++;
            $display("FAIL conn_after_rumble: got %b, expected 1", connected);
        end
    endtask

    task automatic test_framing();
        logic [23:0] cmd;
        int          stop_w, last_w, total, f0, v0;
        bit          legal, ok;
        f0 = n_frm; v0 = n_valid;
        capture_cmd(cmd, stop_w, last_w, total, legal, ok);
        respond(64'h5555_AAAA_5555_AAAA, 20, 9 * C);
        n_tests++;
        if (!ok || n_frm - f0 != 1 || n_valid != v0) begin
            n_fail++;
            $display("FAIL framing_pulse: got %0d framing and %0d valid cycles ok=%0d, expected 1 and 0",
                     n_frm - f0, n_valid - v0, ok);
        end
        n_tests++;
        if (resp_data !== last_good || {connected, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL framing_retain: data=%h conn/busy=%b, expected %h 10",
                     resp_data, {connected, busy}, last_good);
        end
    endtask

    task automatic test_recovery();
        logic [23:0] cmd;
        int          stop_w, last_w, total;
        bit          legal, ok;
        capture_cmd(cmd, stop_w, last_w, total, legal, ok);
        n_tests++;
        if (!ok || cmd !== 24'h400300) begin
            n_fail++;
            $display("FAIL cmd_recovery: got %h ok=%0d, expected 400300", cmd, ok);
        end
        respond(64'h1234_5678_9ABC_DEF0, -1, 0);
        n_tests++;
        if (connected !== 1'b1) begin
            n_fail++;
            $display("FAIL conn_recovery: got %b, expected 1", connected);
        end
    endtask

    task automatic test_reset_mid_tx();
        logic [23:0] cmd;
        int          stop_w, last_w, total, g;
        bit          legal, ok;
        g = 0;
        while (data_w !== 1'b0 && g < 2 * PERIOD) begin @(negedge clk); g++; end
        for (int b = 0; b < 10; b++) begin
            g = 0;
            while (data_w === 1'b0 && g < 1000) begin @(negedge clk); g++; end
            g = 0;
            while (data_w === 1'b1 && g < 1000) begin @(negedge clk); g++; end
        end
        n_tests++;
        if (data_w !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL bit10_reached: line/busy=%b, expected 01", {data_w, busy});
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if (data_w !== 1'b1) begin
            n_fail++;
            $display("FAIL async_release: line=%b, expected 1", data_w);
        end
        n_tests++;
        if ({connected, resp_valid, err_timeout, err_framing, busy} !== 5'b00000 || resp_data !== NEUTRAL) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: conn/valid/tmo/frm/busy=%b data=%h, expected 00000 %h",
                     {connected, resp_valid, err_timeout, err_framing, busy}, resp_data, NEUTRAL);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        capture_cmd(cmd, stop_w, last_w, total, legal, ok);
        n_tests++;
        if (!ok || cmd !== 24'h400300 || total != 97 * C) begin
            n_fail++;
            $display("FAIL repoll_after_reset: got %h total=%0d ok=%0d, expected 400300 total=%0d",
                     cmd, total, ok, 97 * C);
        end
        respond(64'h0000_8181_7F7F_0101, -1, 0);
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_timeout();
        test_rumble();
        test_framing();
        test_recovery();
        test_reset_mid_tx();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d frames never published, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
